noc_mesh_router: RTL and testbench

- Parametrised 5-port (N,S,E,W,L) mesh router; successor to the fixed-position corner/edge routers.
- PORT_MASK selects which ports exist, so one module covers every mesh position.
- Each input has a FIFO; XY dimension-order routing, per-output round-robin arbitration, credit-based flow control, registered outputs.
- Single-flit packets; flit destination in data[7:0].

---
 rtl/noc_mesh_router.sv | 188 ++++++++++++++++++
 tb/tb_noc_mesh_router.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_mesh_router.sv
// noc_mesh_router: 5-port XY mesh router with per-input FIFOs, round-robin output
// arbitration and credit flow control. Optional flit counters under NOC_ROUTER_STATS_EN.
module noc_mesh_router #(
  parameter logic [3:0] XCOORD     = 4'd0,
  parameter logic [3:0] YCOORD     = 4'd0,
  parameter int         DATA_W     = 16,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [4:0] PORT_MASK  = 5'b11111
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [4:0]          in_valid_i,
  input  logic [5*DATA_W-1:0] in_data_i,
  output logic [4:0]          in_credit_o,
  output logic [4:0]          out_valid_o,
  output logic [5*DATA_W-1:0] out_data_o,
  input  logic [4:0]          out_credit_i,
  output logic                drop_o
`ifdef NOC_ROUTER_STATS_EN
  ,
  output logic [5*16-1:0]     stat_fwd_o,
  output logic [15:0]         stat_drop_o
`endif
);

  localparam int NP    = 5;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [NP][FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr [NP];
  logic [PTR_W-1:0]  wr_ptr [NP];
  logic [CNT_W-1:0]  fifo_cnt [NP];
  logic [CNT_W-1:0]  credit [NP];
  logic [2:0]        rr_ptr [NP];
  logic [DATA_W-1:0] out_data_r [NP];
  logic [NP-1:0]     out_valid_r;
  logic [NP-1:0]     in_credit_r;
  logic              drop_r;

  logic [DATA_W-1:0] head [NP];
  logic [2:0]        route [NP];
  logic [NP-1:0]     head_vld, mask_drop, pop, accept, full_drop, fire;
  logic [NP-1:0]     req [NP];
  logic [2:0]        grantee [NP];
  logic [DATA_W-1:0] sel_data [NP];

  // Port order N=0, S=1, E=2, W=3, L=4.
  function automatic logic [2:0] xy_route(input logic [7:0] dest);
    if (dest[7:4] > XCOORD)      return 3'd2;
    else if (dest[7:4] < XCOORD) return 3'd3;
    else if (dest[3:0] > YCOORD) return 3'd0;
    else if (dest[3:0] < YCOORD) return 3'd1;
    else                         return 3'd4;
  endfunction

  function automatic logic [2:0] rr_idx(input logic [2:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NP) s = s - NP;
    return 3'(s);
  endfunction

  always_comb begin
    head_vld  = '0;
    mask_drop = '0;
    pop       = '0;
    accept    = '0;
    full_drop = '0;
    fire      = '0;
    for (int i = 0; i < NP; i++) begin
      head[i]      = mem[i][rd_ptr[i]];
      route[i]     = xy_route(head[i][7:0]);
      head_vld[i]  = PORT_MASK[i] && (fifo_cnt[i] != '0);
      // A head routed to a missing port can never leave, so discard it.
      mask_drop[i] = head_vld[i] && !PORT_MASK[route[i]];
      pop[i]       = mask_drop[i];
    end
    for (int o = 0; o < NP; o++) begin
      req[o] = '0;
      for (int i = 0; i < NP; i++)
        req[o][i] = head_vld[i] && (route[i] == 3'(o)) && PORT_MASK[o];
    end
    for (int o = 0; o < NP; o++) begin
      grantee[o]  = '0;
      sel_data[o] = '0;
      if (PORT_MASK[o] && (credit[o] != '0)) begin
        for (int k = 0; k < NP; k++) begin
          if (!fire[o] && req[o][rr_idx(rr_ptr[o], k)]) begin
            fire[o]    = 1'b1;
            grantee[o] = rr_idx(rr_ptr[o], k);
          end
        end
      end
      if (fire[o]) begin
        pop[grantee[o]] = 1'b1;
        sel_data[o]     = head[grantee[o]];
      end
    end
    for (int i = 0; i < NP; i++) begin
      accept[i]    = in_valid_i[i] && PORT_MASK[i] && ((fifo_cnt[i] != DEPTH_C) || pop[i]);
      full_drop[i] = in_valid_i[i] && PORT_MASK[i] && !accept[i];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NP; i++)
      if (accept[i]) mem[i][wr_ptr[i]] <= in_data_i[i*DATA_W +: DATA_W];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NP; i++) begin
        rd_ptr[i]     <= '0;
        wr_ptr[i]     <= '0;
        fifo_cnt[i]   <= '0;
        credit[i]     <= DEPTH_C;
        rr_ptr[i]     <= '0;
        out_data_r[i] <= '0;
      end
      out_valid_r <= '0;
      in_credit_r <= '0;
      drop_r      <= 1'b0;
    end else begin
      for (int i = 0; i < NP; i++) begin
        if (accept[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])    rd_ptr[i] <= rd_ptr[i] + 1'b1;
        if (accept[i] && !pop[i])      fifo_cnt[i] <= fifo_cnt[i] + 1'b1;
        else if (!accept[i] && pop[i]) fifo_cnt[i] <= fifo_cnt[i] - 1'b1;
      end
      for (int o = 0; o < NP; o++) begin
        out_valid_r[o] <= fire[o];
        if (fire[o]) begin
          out_data_r[o] <= sel_data[o];
          rr_ptr[o]     <= rr_idx(grantee[o], 1);
        end
        // Send and returning credit in one cycle cancel; counter saturates at depth.
        if (fire[o] && !out_credit_i[o])
          credit[o] <= credit[o] - 1'b1;
        else if (!fire[o] && out_credit_i[o] && (credit[o] != DEPTH_C))
          credit[o] <= credit[o] + 1'b1;
      end
      in_credit_r <= pop & PORT_MASK;
      drop_r      <= (|full_drop) | (|mask_drop);
    end
  end

  always_comb begin
    out_valid_o = '0;
    out_data_o  = '0;
    for (int o = 0; o < NP; o++) begin
      out_valid_o[o] = out_valid_r[o] & PORT_MASK[o];
      out_data_o[o*DATA_W +: DATA_W] = PORT_MASK[o] ? out_data_r[o] : '0;
    end
  end

  assign in_credit_o = in_credit_r & PORT_MASK;
  assign drop_o      = drop_r;

`ifdef NOC_ROUTER_STATS_EN
  logic [15:0] fwd_cnt [NP];
  logic [15:0] drop_cnt;
  logic [16:0] drop_sum;

  always_comb
    drop_sum = {1'b0, drop_cnt} + 17'($countones(full_drop)) + 17'($countones(mask_drop));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int o = 0; o < NP; o++) fwd_cnt[o] <= '0;
      drop_cnt <= '0;
    end else begin
      for (int o = 0; o < NP; o++)
        if (fire[o] && (fwd_cnt[o] != 16'hFFFF)) fwd_cnt[o] <= fwd_cnt[o] + 1'b1;
      drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

  always_comb begin
    stat_fwd_o = '0;
    for (int o = 0; o < NP; o++) stat_fwd_o[o*16 +: 16] = fwd_cnt[o];
  end

  assign stat_drop_o = drop_cnt;
`endif

endmodule

// File: tb/tb_noc_mesh_router.sv
// tb_noc_mesh_router: directed self-checking bench for noc_mesh_router, using a
// full-mask router at (1,1) and a router at (0,0) without N and S ports.
module tb_noc_mesh_router;
  localparam int DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [4:0]      in_valid, out_credit, in_credit, out_valid;
  logic [5*DW-1:0] in_data, out_data;
  logic            drop;
  logic [4:0]      m_in_valid, m_out_credit, m_in_credit, m_out_valid;
  logic [5*DW-1:0] m_in_data, m_out_data;
  logic            m_drop;
`ifdef NOC_ROUTER_STATS_EN
  logic [5*16-1:0] stat_fwd, m_stat_fwd;
  logic [15:0]     stat_drop, m_stat_drop;
`endif

  int checks = 0;
  int errors = 0;
  int fwd_cnt [5];
  int icr_cnt [5];
  int drop_cnt, m_drop_cnt, m_fwd_cnt, m_icr_cnt;
  logic [DW-1:0] q_e [$];

  noc_mesh_router #(.XCOORD(4'd1), .YCOORD(4'd1), .DATA_W(DW), .FIFO_DEPTH(4),
                    .PORT_MASK(5'b11111)) dut (
    .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_data_i(in_data),
    .in_credit_o(in_credit), .out_valid_o(out_valid), .out_data_o(out_data),
    .out_credit_i(out_credit), .drop_o(drop)
`ifdef NOC_ROUTER_STATS_EN
    , .stat_fwd_o(stat_fwd), .stat_drop_o(stat_drop)
`endif
  );

  noc_mesh_router #(.XCOORD(4'd0), .YCOORD(4'd0), .DATA_W(DW), .FIFO_DEPTH(4),
                    .PORT_MASK(5'b11100)) dut_m (
    .clk(clk), .rst(rst), .in_valid_i(m_in_valid), .in_data_i(m_in_data),
    .in_credit_o(m_in_credit), .out_valid_o(m_out_valid), .out_data_o(m_out_data),
    .out_credit_i(m_out_credit), .drop_o(m_drop)
`ifdef NOC_ROUTER_STATS_EN
    , .stat_fwd_o(m_stat_fwd), .stat_drop_o(m_stat_drop)
`endif
  );

  task automatic clear_obs();
    for (int p = 0; p < 5; p++) begin
      fwd_cnt[p] = 0;
      icr_cnt[p] = 0;
    end
    drop_cnt = 0; m_drop_cnt = 0; m_fwd_cnt = 0; m_icr_cnt = 0;
    q_e.delete();
  endtask

  // Advance one clock and log everything visible just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int p = 0; p < 5; p++) begin
      if (out_valid[p]) fwd_cnt[p]++;
      if (in_credit[p]) icr_cnt[p]++;
    end
    if (out_valid[2]) q_e.push_back(out_data[2*DW +: DW]);
    if (drop) drop_cnt++;
    if (m_drop) m_drop_cnt++;
    if (m_out_valid != 5'b0) m_fwd_cnt++;
    if (m_in_credit != 5'b0) m_icr_cnt++;
  endtask

  task automatic drive(input int p, input logic [DW-1:0] d);
    in_valid[p] = 1'b1;
    in_data[p*DW +: DW] = d;
  endtask

  task automatic idle();
    in_valid = '0;
  endtask

  task automatic do_reset();
    in_valid = '0; m_in_valid = '0; out_credit = '0; m_out_credit = '0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    clear_obs();
  endtask

  task automatic test_reset();
    checks++;
    if (out_valid !== 5'b0 || in_credit !== 5'b0 || drop !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got valid=%b credit=%b drop=%b expected all 0", out_valid, in_credit, drop);
    end
    checks++;
    if (out_data !== '0) begin
      errors++;
      $display("FAIL reset_data: got %h expected 0", out_data);
    end
    checks++;
    if (m_out_valid !== 5'b0 || m_in_credit !== 5'b0 || m_drop !== 1'b0 || m_out_data !== '0) begin
      errors++;
      $display("FAIL reset_masked: got valid=%b credit=%b drop=%b expected all 0", m_out_valid, m_in_credit, m_drop);
    end
  endtask

  task automatic test_latency();
    do_reset();
    drive(4, 16'hAB21); tick(); idle();
    checks++;
    if (out_valid !== 5'b0) begin
      errors++; $display("FAIL lat_early: got %b expected 00000", out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 5'b00100) begin
      errors++; $display("FAIL lat_valid: got %b expected 00100", out_valid);
    end
    checks++;
    if (out_data[2*DW +: DW] !== 16'hAB21) begin
      errors++; $display("FAIL lat_data: got %h expected ab21", out_data[2*DW +: DW]);
    end
    checks++;
    if (in_credit !== 5'b10000) begin
      errors++; $display("FAIL lat_credit: got %b expected 10000", in_credit);
    end
    tick();
    checks++;
    if (out_valid !== 5'b0 || in_credit !== 5'b0) begin
      errors++; $display("FAIL lat_pulse: got valid=%b credit=%b expected 0", out_valid, in_credit);
    end
  endtask

  task automatic test_rr_contention();
    logic [DW-1:0] exp_d [3];
    logic [4:0]    exp_c [3];
    exp_d = '{16'h0011, 16'h1011, 16'h3011};
    exp_c = '{5'b00001, 5'b00010, 5'b01000};
    do_reset();
    out_credit[4] = 1'b1;
    drive(0, 16'h0011); drive(1, 16'h1011); drive(3, 16'h3011); tick(); idle();
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (out_valid[4] !== 1'b1 || out_data[4*DW +: DW] !== exp_d[k]) begin
        errors++;
        $display("FAIL rr_order%0d: got v=%b d=%h expected v=1 d=%h", k, out_valid[4], out_data[4*DW +: DW], exp_d[k]);
      end
      checks++;
      if (in_credit !== exp_c[k]) begin
        errors++; $display("FAIL rr_credit%0d: got %b expected %b", k, in_credit, exp_c[k]);
      end
    end
    tick();
    checks++;
    if (out_valid !== 5'b0) begin
      errors++; $display("FAIL rr_idle: got %b expected 00000", out_valid);
    end
    // Pointer now sits past W (index 4), so L wins over E in the next round.
    drive(2, 16'h2A11); drive(4, 16'h4A11); tick(); idle();
    tick();
    checks++;
    if (out_valid[4] !== 1'b1 || out_data[4*DW +: DW] !== 16'h4A11) begin
      errors++; $display("FAIL rr_wrap_first: got %h expected 4a11", out_data[4*DW +: DW]);
    end
    tick();
    checks++;
    if (out_valid[4] !== 1'b1 || out_data[4*DW +: DW] !== 16'h2A11) begin
      errors++; $display("FAIL rr_wrap_second: got %h expected 2a11", out_data[4*DW +: DW]);
    end
    out_credit = '0;
  endtask

  task automatic test_credit_stall();
    do_reset();
    for (int k = 0; k < 6; k++) begin
      drive(4, {4'hC, 4'(k), 8'h21}); tick();
    end
    idle(); repeat (4) tick();
    checks++;
    if (fwd_cnt[2] != 4 || drop_cnt != 0 || icr_cnt[4] != 4) begin
      errors++;
      $display("FAIL stall_count: got fwd=%0d drop=%0d icr=%0d expected 4 0 4", fwd_cnt[2], drop_cnt, icr_cnt[4]);
    end
    checks++;
    if (q_e.size() != 4 || q_e[3] !== 16'hC321) begin
      errors++; $display("FAIL stall_last: got size=%0d expected 4 ending c321", q_e.size());
    end
    out_credit[2] = 1'b1; tick(); out_credit[2] = 1'b0;
    repeat (4) tick();
    checks++;
    if (fwd_cnt[2] != 5 || q_e.size() != 5 || q_e[4] !== 16'hC421) begin
      errors++; $display("FAIL stall_release: got fwd=%0d expected 5 ending c421", fwd_cnt[2]);
    end
  endtask

  task automatic test_credit_edges();
    do_reset();
    out_credit[2] = 1'b1; tick();
    for (int k = 0; k < 6; k++) begin
      drive(4, {4'h6, 4'(k), 8'h21}); tick();
    end
    idle(); tick();
    out_credit[2] = 1'b0;
    checks++;
    if (fwd_cnt[2] != 6) begin
      errors++; $display("FAIL cred_simul: got fwd=%0d expected 6", fwd_cnt[2]);
    end
    for (int k = 0; k < 5; k++) begin
      drive(4, {4'h7, 4'(k), 8'h21}); tick();
    end
    idle(); repeat (4) tick();
    checks++;
    if (fwd_cnt[2] != 10 || drop_cnt != 0) begin
      errors++; $display("FAIL cred_sat: got fwd=%0d drop=%0d expected 10 0", fwd_cnt[2], drop_cnt);
    end
  endtask

  task automatic test_masked_port();
    do_reset();
    m_in_valid[4] = 1'b1; m_in_data[4*DW +: DW] = 16'h5503; tick(); m_in_valid = '0;
    checks++;
    if (m_drop !== 1'b0) begin
      errors++; $display("FAIL mask_early: got drop=%b expected 0", m_drop);
    end
    tick();
    checks++;
    if (m_drop !== 1'b1 || m_in_credit !== 5'b10000 || m_out_valid !== 5'b0) begin
      errors++;
      $display("FAIL mask_drop: got drop=%b credit=%b valid=%b expected 1 10000 00000", m_drop, m_in_credit, m_out_valid);
    end
    tick();
    checks++;
    if (m_drop !== 1'b0 || m_in_credit !== 5'b0) begin
      errors++; $display("FAIL mask_pulse: got drop=%b credit=%b expected 0", m_drop, m_in_credit);
    end
    m_in_valid[0] = 1'b1; m_in_data[0 +: DW] = 16'h5500; tick(); m_in_valid = '0;
    repeat (3) tick();
    checks++;
    if (m_fwd_cnt != 0 || m_icr_cnt != 1 || m_drop_cnt != 1) begin
      errors++;
      $display("FAIL mask_ignore: got fwd=%0d icr=%0d drop=%0d expected 0 1 1", m_fwd_cnt, m_icr_cnt, m_drop_cnt);
    end
    m_in_valid[4] = 1'b1; m_in_data[4*DW +: DW] = 16'h5510; tick(); m_in_valid = '0;
    tick();
    checks++;
    if (m_out_valid !== 5'b00100 || m_out_data[2*DW +: DW] !== 16'h5510) begin
      errors++; $display("FAIL mask_route: got v=%b d=%h expected 00100 5510", m_out_valid, m_out_data[2*DW +: DW]);
    end
  endtask

  task automatic test_fifo_full_drop();
    logic [DW-1:0] exp_q [9];
    exp_q = '{16'hD021, 16'hD121, 16'hD221, 16'hD321, 16'hE021, 16'hE121, 16'hE221, 16'hE321, 16'hF021};
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive(4, {4'hD, 4'(k), 8'h21}); tick();
    end
    idle(); repeat (2) tick();
    checks++;
    if (fwd_cnt[2] != 4) begin
      errors++; $display("FAIL full_drain: got fwd=%0d expected 4", fwd_cnt[2]);
    end
    for (int k = 0; k < 4; k++) begin
      drive(4, {4'hE, 4'(k), 8'h21}); tick();
    end
    checks++;
    if (drop_cnt != 0) begin
      errors++; $display("FAIL full_fill: got drops=%0d expected 0", drop_cnt);
    end
    drive(4, 16'hE421); tick(); idle();
    checks++;
    if (drop !== 1'b1) begin
      errors++; $display("FAIL full_drop: got %b expected 1", drop);
    end
    tick();
    checks++;
    if (drop !== 1'b0 || drop_cnt != 1) begin
      errors++; $display("FAIL full_pulse: got drop=%b count=%0d expected 0 1", drop, drop_cnt);
    end
    out_credit[2] = 1'b1; tick(); out_credit[2] = 1'b0;
    drive(4, 16'hF021); tick(); idle();
    checks++;
    if (drop !== 1'b0 || out_valid[2] !== 1'b1 || out_data[2*DW +: DW] !== 16'hE021) begin
      errors++;
      $display("FAIL full_pushpop: got drop=%b v=%b d=%h expected 0 1 e021", drop, out_valid[2], out_data[2*DW +: DW]);
    end
    out_credit[2] = 1'b1; repeat (4) tick(); out_credit[2] = 1'b0;
    repeat (3) tick();
    checks++;
    if (q_e.size() != 9 || drop_cnt != 1) begin
      errors++; $display("FAIL full_total: got size=%0d drops=%0d expected 9 1", q_e.size(), drop_cnt);
    end
    for (int k = 0; k < 9; k++) begin
      checks++;
      if (q_e.size() <= k || q_e[k] !== exp_q[k]) begin
        errors++; $display("FAIL full_order%0d: expected %h (queue size %0d)", k, exp_q[k], q_e.size());
      end
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive(4, {4'h7, 4'(k), 8'h21}); tick();
    end
    idle();
    checks++;
    if (out_valid[2] !== 1'b1 || out_data[2*DW +: DW] !== 16'h7121) begin
      errors++; $display("FAIL rstmid_pre: got v=%b d=%h expected 1 7121", out_valid[2], out_data[2*DW +: DW]);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 5'b0 || in_credit !== 5'b0 || drop !== 1'b0 || out_data !== '0) begin
      errors++;
      $display("FAIL rstmid_async: got v=%b c=%b drop=%b expected all 0", out_valid, in_credit, drop);
    end
    tick(); tick();
    rst = 1'b0;
    clear_obs();
    repeat (3) tick();
    checks++;
    if (fwd_cnt[2] != 0 || icr_cnt[4] != 0 || drop_cnt != 0) begin
      errors++;
      $display("FAIL rstmid_flush: got fwd=%0d icr=%0d drop=%0d expected 0", fwd_cnt[2], icr_cnt[4], drop_cnt);
    end
    drive(4, 16'h7921); tick(); idle();
    checks++;
    if (out_valid !== 5'b0) begin
      errors++; $display("FAIL rstmid_early: got %b expected 00000", out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 5'b00100 || out_data[2*DW +: DW] !== 16'h7921) begin
      errors++; $display("FAIL rstmid_lat: got v=%b d=%h expected 00100 7921", out_valid, out_data[2*DW +: DW]);
    end
    for (int k = 0; k < 4; k++) begin
      drive(4, {4'h8, 4'(k), 8'h21}); tick();
    end
    idle(); repeat (4) tick();
    checks++;
    if (fwd_cnt[2] != 4) begin
      errors++; $display("FAIL rstmid_credits: got fwd=%0d expected 4", fwd_cnt[2]);
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    in_valid = '0; in_data = '0; out_credit = '0;
    m_in_valid = '0; m_in_data = '0; m_out_credit = '0;
    clear_obs();
    #2 rst = 1'b1;
    #1;
    test_reset();
    test_latency();
    test_rr_contention();
    test_credit_stall();
    test_credit_edges();
    test_masked_port();
    test_fifo_full_drop();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
